// File: rtl/seq1001_moore_detector.sv
// Moore FSM that detects the serial pattern 1-0-0-1 and keeps a saturating detection count.
// Define SEQ1001_OVERLAP_EN to let the trailing 1 of a match start the next one.
module seq1001_moore_detector #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] det_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S10  = 3'd2,
        S100 = 3'd3,
        DET  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = in ? S1 : IDLE;
            S1:      w_next = in ? S1 : S10;
            S10:     w_next = in ? S1 : S100;
            S100:    w_next = in ? DET : IDLE;
`ifdef SEQ1001_OVERLAP_EN
            DET:     w_next = in ? S1 : S10;
`else
            DET:     w_next = in ? S1 : IDLE;
`endif
            default: w_next = IDLE;
        endcase
    end

    // out is registered from the next state so it equals (state == DET) with no path from in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_out   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= (w_next == DET);
            if ((w_next == DET) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out     = r_out;
    assign det_cnt = r_cnt;

endmodule

// File: tb/tb_seq1001_moore_detector.sv
// Directed self-checking bench for seq1001_moore_detector (default and 2-bit counter instances).
module tb_seq1001_moore_detector;

    logic       clk;
    logic       rst;
    logic       in;
    logic       out8;
    logic [7:0] cnt8;
    logic       out2;
    logic [1:0] cnt2;

    int unsigned n_checks;
    int unsigned n_errors;

    seq1001_moore_detector #(.CNT_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .out     (out8),
        .det_cnt (cnt8)
    );

    seq1001_moore_detector #(.CNT_W(2)) u_dut_sat (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .out     (out2),
        .det_cnt (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one bit, let it be sampled, then check out and det_cnt just after the edge.
    task automatic step(input string tag, input logic b, input logic eo, input int unsigned ec);
        in = b;
        @(posedge clk);
        #1;
        check({tag, "_out"}, 32'(out8), 32'(eo));
        check({tag, "_cnt"}, 32'(cnt8), ec);
    endtask

    // Pulse reset between scenarios, away from the clock edge.
    task automatic do_reset();
        in = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        in  = 1'b0;

        // Reset asserted with arbitrary in and running clock
        #2 rst = 1'b0;
        #1;
        check("rst_imm_out", 32'(out8), 0);
        check("rst_imm_cnt", 32'(cnt8), 0);
        for (int i = 0; i < 6; i++) begin
            in = (i % 3 != 1);
            @(posedge clk);
            #1;
            check("rst_hold_out", 32'(out8), 0);
            check("rst_hold_cnt", 32'(cnt8), 0);
        end
        rst = 1'b1;
        step("idle0", 1'b0, 1'b0, 0);
        step("idle1", 1'b0, 1'b0, 0);
        step("idle2", 1'b0, 1'b0, 0);

        // Basic detect 1,0,0,1,0
        do_reset();
        step("basic1", 1'b1, 1'b0, 0);
        step("basic2", 1'b0, 1'b0, 0);
        step("basic3", 1'b0, 1'b0, 0);
        step("basic4", 1'b1, 1'b1, 1);
        step("basic5", 1'b0, 1'b0, 1);

        // 1,0,0,1,0,0,1,0: one pulse non-overlapping, two when overlapping
        do_reset();
        step("ovl1", 1'b1, 1'b0, 0);
        step("ovl2", 1'b0, 1'b0, 0);
        step("ovl3", 1'b0, 1'b0, 0);
        step("ovl4", 1'b1, 1'b1, 1);
        step("ovl5", 1'b0, 1'b0, 1);
        step("ovl6", 1'b0, 1'b0, 1);
`ifdef SEQ1001_OVERLAP_EN
        step("ovl7", 1'b1, 1'b1, 2);
        step("ovl8", 1'b0, 1'b0, 2);
`else
        step("ovl7", 1'b1, 1'b0, 1);
        step("ovl8", 1'b0, 1'b0, 1);
`endif

        // Back-to-back 1,0,0,1,1,0,0,1
        do_reset();
        step("b2b1", 1'b1, 1'b0, 0);
        step("b2b2", 1'b0, 1'b0, 0);
        step("b2b3", 1'b0, 1'b0, 0);
        step("b2b4", 1'b1, 1'b1, 1);
        step("b2b5", 1'b1, 1'b0, 1);
        step("b2b6", 1'b0, 1'b0, 1);
        step("b2b7", 1'b0, 1'b0, 1);
        step("b2b8", 1'b1, 1'b1, 2);

        // Near-miss 1,0,1,0,0,0,1
        do_reset();
        step("nm_a1", 1'b1, 1'b0, 0);
        step("nm_a2", 1'b0, 1'b0, 0);
        step("nm_a3", 1'b1, 1'b0, 0);
        step("nm_a4", 1'b0, 1'b0, 0);
        step("nm_a5", 1'b0, 1'b0, 0);
        step("nm_a6", 1'b0, 1'b0, 0);
        step("nm_a7", 1'b1, 1'b0, 0);

        // Near-miss 1,1,0,1
        do_reset();
        step("nm_b1", 1'b1, 1'b0, 0);
        step("nm_b2", 1'b1, 1'b0, 0);
        step("nm_b3", 1'b0, 1'b0, 0);
        step("nm_b4", 1'b1, 1'b0, 0);

        // 1,1,1,0,0,1 detects on the last bit
        do_reset();
        step("ones1", 1'b1, 1'b0, 0);
        step("ones2", 1'b1, 1'b0, 0);
        step("ones3", 1'b1, 1'b0, 0);
        step("ones4", 1'b0, 1'b0, 0);
        step("ones5", 1'b0, 1'b0, 0);
        step("ones6", 1'b1, 1'b1, 1);

        // Asynchronous reset while in S100 after one detection
        do_reset();
        step("mid1", 1'b1, 1'b0, 0);
        step("mid2", 1'b0, 1'b0, 0);
        step("mid3", 1'b0, 1'b0, 0);
        step("mid4", 1'b1, 1'b1, 1);
        step("mid5", 1'b1, 1'b0, 1);
        step("mid6", 1'b0, 1'b0, 1);
        step("mid7", 1'b0, 1'b0, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_async_out", 32'(out8), 0);
        check("mid_async_cnt", 32'(cnt8), 0);
        in = 1'b1;
        @(posedge clk);
        #1;
        check("mid_hold_out", 32'(out8), 0);
        check("mid_hold_cnt", 32'(cnt8), 0);
        rst = 1'b1;
        step("mid_after", 1'b1, 1'b0, 0);
        step("mid_after2", 1'b0, 1'b0, 0);

        // Saturation on the 2-bit counter over five detections
        do_reset();
        for (int d = 1; d <= 5; d++) begin
            step("sat_b1", 1'b1, 1'b0, 32'(d - 1));
            step("sat_b2", 1'b0, 1'b0, 32'(d - 1));
            step("sat_b3", 1'b0, 1'b0, 32'(d - 1));
            step("sat_b4", 1'b1, 1'b1, 32'(d));
            check("sat_out2", 32'(out2), 1);
            check("sat_cnt2", 32'(cnt2), (d < 3) ? 32'(d) : 32'd3);
        end
        step("sat_tail", 1'b0, 1'b0, 5);
        check("sat_tail_out2", 32'(out2), 0);
        check("sat_tail_cnt2", 32'(cnt2), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
